// File: rtl/inport_buffered_pkg.sv
// Shared definitions for the buffered router input port.
// Holds the route index constants for the one-hot route vector, the number of
// router ports, and a constant clog2 helper used to size pointers and counters.
package inport_buffered_pkg;

    localparam int NUM_PORTS   = 5;

    localparam int ROUTE_LOCAL = 4;
    localparam int ROUTE_NORTH = 3;
    localparam int ROUTE_SOUTH = 2;
    localparam int ROUTE_EAST  = 1;
    localparam int ROUTE_WEST  = 0;

    // Ceiling log2, usable in parameter and port-width expressions
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/inport_fifo.sv
// Flit FIFO for the buffered input port.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   push_req, din   upstream flit valid and data
//   pop_req         allocator grant for the head flit
//   pop             grant accepted this cycle (FIFO was not empty)
//   count           occupancy, 0..FIFO_DEPTH
//   overflow        sticky flag: push attempted while full with no pop
//   head_valid_nxt  FIFO will be non-empty after this edge
//   head_data_nxt   flit that will be at the head after this edge (0 if empty)
// The look-ahead head outputs let the parent register the head flit so a flit
// pushed into an empty FIFO is presented exactly one edge later.
module inport_fifo
    import inport_buffered_pkg::*;
#(
    parameter  int DATA_W     = 48,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = clog2(FIFO_DEPTH),
    localparam int CNT_W      = clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req,
    input  logic [DATA_W-1:0] din,
    input  logic              pop_req,
    output logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              head_valid_nxt,
    output logic [DATA_W-1:0] head_data_nxt
);

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  next_rd_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  remaining_s;
    logic              overflow_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;

    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign pop_s     = pop_req && !empty_s;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_s    = push_req && (!full_s || pop_s);
    assign next_rd_s = pop_s ? (rd_ptr_r + PTR_W'(1'b1)) : rd_ptr_r;
    // Entries that survive this edge, not counting the one being pushed
    assign remaining_s = count_r - CNT_W'(pop_s);

    // Storage write; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            rd_ptr_r <= next_rd_s;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
            if (push_req && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Look-ahead head: an old entry if one survives, else the flit being pushed
    always_comb begin
        head_data_nxt = {DATA_W{1'b0}};
        if (remaining_s != {CNT_W{1'b0}}) begin
            head_data_nxt = mem_r[next_rd_s];
        end else if (push_s) begin
            head_data_nxt = din;
        end else begin
            head_data_nxt = {DATA_W{1'b0}};
        end
    end

    assign head_valid_nxt = (remaining_s != {CNT_W{1'b0}}) || push_s;
    assign pop            = pop_s;
    assign count          = count_r;
    assign overflow       = overflow_r;

endmodule

// File: rtl/inport_buffered.sv
// Buffered router input port.
// Buffers upstream flits, presents the registered head flit with its XY route
// request to the switch allocator, and returns one credit per flit consumed.
// Ports:
//   clka, rsta      clock and asynchronous active-low reset
//   valid_din       upstream flit valid
//   channel_din     upstream flit; X dest in the top COORD_W bits, Y dest below
//   grant_din       allocator consumes the head flit this cycle
//   credit_dout     one-cycle pulse in the cycle after each pop
//   request_dout    head flit present
//   route_dout      one-hot route [4]=local [3]=north [2]=south [1]=east [0]=west
//   x_hit_dout      head X dest equals X_LOCAL
//   y_hit_dout      head Y dest equals Y_LOCAL
//   packet_dout     head flit, 0 when empty
//   overflow_dout   sticky overflow flag
//   count_dout      occupancy
module inport_buffered
    import inport_buffered_pkg::*;
#(
    parameter int X_LOCAL    = 2,
    parameter int Y_LOCAL    = 2,
    parameter int COORD_W    = 4,
    parameter int DATA_W     = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clka,
    input  logic                               rsta,
    input  logic                               valid_din,
    input  logic [DATA_W-1:0]                  channel_din,
    output logic                               credit_dout,
    output logic                               request_dout,
    output logic [NUM_PORTS-1:0]               route_dout,
    output logic                               x_hit_dout,
    output logic                               y_hit_dout,
    output logic [DATA_W-1:0]                  packet_dout,
    input  logic                               grant_din,
    output logic                               overflow_dout,
    output logic [clog2(FIFO_DEPTH+1)-1:0]     count_dout
);

    localparam int CNT_W = clog2(FIFO_DEPTH + 1);
    localparam logic [COORD_W-1:0] X_LOC = COORD_W'(X_LOCAL);
    localparam logic [COORD_W-1:0] Y_LOC = COORD_W'(Y_LOCAL);

    logic                 pop_s;
    logic                 head_valid_nxt_s;
    logic [DATA_W-1:0]    head_data_nxt_s;
    logic [CNT_W-1:0]     count_s;
    logic                 overflow_s;
    logic [COORD_W-1:0]   x_dest_s;
    logic [COORD_W-1:0]   y_dest_s;
    logic [NUM_PORTS-1:0] route_s;
    logic                 x_hit_s;
    logic                 y_hit_s;

    logic                 credit_r;
    logic                 request_r;
    logic [NUM_PORTS-1:0] route_r;
    logic                 x_hit_r;
    logic                 y_hit_r;
    logic [DATA_W-1:0]    packet_r;

    inport_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clka),
        .rst_n          (rsta),
        .push_req       (valid_din),
        .din            (channel_din),
        .pop_req        (grant_din),
        .pop            (pop_s),
        .count          (count_s),
        .overflow       (overflow_s),
        .head_valid_nxt (head_valid_nxt_s),
        .head_data_nxt  (head_data_nxt_s)
    );

    assign x_dest_s = head_data_nxt_s[DATA_W-1 -: COORD_W];
    assign y_dest_s = head_data_nxt_s[DATA_W-COORD_W-1 -: COORD_W];

    // Dimension-order route decode of the upcoming head; all zero when empty
    always_comb begin
        route_s = {NUM_PORTS{1'b0}};
        x_hit_s = 1'b0;
        y_hit_s = 1'b0;
        if (head_valid_nxt_s) begin
            x_hit_s = (x_dest_s == X_LOC);
            y_hit_s = (y_dest_s == Y_LOC);
            if (x_dest_s > X_LOC) begin
                route_s[ROUTE_EAST] = 1'b1;
            end else if (x_dest_s < X_LOC) begin
                route_s[ROUTE_WEST] = 1'b1;
            end else if (y_dest_s > Y_LOC) begin
                route_s[ROUTE_NORTH] = 1'b1;
            end else if (y_dest_s < Y_LOC) begin
                route_s[ROUTE_SOUTH] = 1'b1;
            end else begin
                route_s[ROUTE_LOCAL] = 1'b1;
            end
        end else begin
            route_s = {NUM_PORTS{1'b0}};
        end
    end

    // Head, route and credit registers
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            credit_r  <= 1'b0;
            request_r <= 1'b0;
            route_r   <= {NUM_PORTS{1'b0}};
            x_hit_r   <= 1'b0;
            y_hit_r   <= 1'b0;
            packet_r  <= {DATA_W{1'b0}};
        end else begin
            credit_r  <= pop_s;
            request_r <= head_valid_nxt_s;
            route_r   <= route_s;
            x_hit_r   <= x_hit_s;
            y_hit_r   <= y_hit_s;
            packet_r  <= head_data_nxt_s;
        end
    end

    assign credit_dout   = credit_r;
    assign request_dout  = request_r;
    assign route_dout    = route_r;
    assign x_hit_dout    = x_hit_r;
    assign y_hit_dout    = y_hit_r;
    assign packet_dout   = packet_r;
    assign overflow_dout = overflow_s;
    assign count_dout    = count_s;

endmodule

// File: tb/tb_inport_buffered.sv
// Self-checking bench for inport_buffered: a queue scoreboard holds the flits
// expected in the FIFO; every cycle the registered outputs are compared
// against the head of that queue and an XY route model.
module tb_inport_buffered;

    localparam int DEPTH = 4;

    logic        clka        = 1'b0;
    logic        rsta        = 1'b0;
    logic        valid_din   = 1'b0;
    logic [47:0] channel_din = 48'h0;
    logic        grant_din   = 1'b0;
    logic        credit_dout;
    logic        request_dout;
    logic [4:0]  route_dout;
    logic        x_hit_dout;
    logic        y_hit_dout;
    logic [47:0] packet_dout;
    logic        overflow_dout;
    logic [2:0]  count_dout;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          credit_tally = 0;
    bit          mdl_ovf      = 1'b0;
    logic [47:0] sb[$];

    inport_buffered dut (
        .clka          (clka),
        .rsta          (rsta),
        .valid_din     (valid_din),
        .channel_din   (channel_din),
        .credit_dout   (credit_dout),
        .request_dout  (request_dout),
        .route_dout    (route_dout),
        .x_hit_dout    (x_hit_dout),
        .y_hit_dout    (y_hit_dout),
        .packet_dout   (packet_dout),
        .grant_din     (grant_din),
        .overflow_dout (overflow_dout),
        .count_dout    (count_dout)
    );

    always #5 clka = ~clka;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [47:0] mk(input logic [3:0] x, input logic [3:0] y,
                                        input logic [39:0] payload);
        return {x, y, payload};
    endfunction

    function automatic logic [4:0] exp_route(input logic [47:0] f);
        logic [3:0] x;
        logic [3:0] y;
        x = f[47:44];
        y = f[43:40];
        if (x > 4'd2)      return 5'b00010;
        else if (x < 4'd2) return 5'b00001;
        else if (y > 4'd2) return 5'b01000;
        else if (y < 4'd2) return 5'b00100;
        else               return 5'b10000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input logic exp_credit);
        logic [47:0] head;
        bit          nonempty;
        nonempty = (sb.size() > 0);
        head     = nonempty ? sb[0] : 48'h0;
        check("credit",   64'(credit_dout),   64'(exp_credit));
        check("count",    64'(count_dout),    64'(sb.size()));
        check("request",  64'(request_dout),  64'(nonempty));
        check("overflow", 64'(overflow_dout), 64'(mdl_ovf));
        check("packet",   64'(packet_dout),   64'(head));
        check("route",    64'(route_dout),    nonempty ? 64'(exp_route(head)) : 64'h0);
        check("x_hit",    64'(x_hit_dout),    64'(nonempty && head[47:44] == 4'd2));
        check("y_hit",    64'(y_hit_dout),    64'(nonempty && head[43:40] == 4'd2));
    endtask

    // One clock cycle of stimulus; called at 1 time unit after a rising edge
    task automatic cycle(input logic v, input logic [47:0] d, input logic g);
        bit pop;
        bit push;
        int n;
        n    = sb.size();
        pop  = g && (n > 0);
        push = v && ((n < DEPTH) || pop);
        if (v && (n == DEPTH) && !pop) mdl_ovf = 1'b1;
        valid_din   = v;
        channel_din = d;
        grant_din   = g;
        @(posedge clka);
        #1;
        valid_din = 1'b0;
        grant_din = 1'b0;
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(d);
        if (credit_dout) credit_tally++;
        check_state(pop);
    endtask

    task automatic async_reset();
        rsta = 1'b0;
        #1;
        sb.delete();
        mdl_ovf = 1'b0;
        check_state(1'b0);
        @(negedge clka);
        rsta = 1'b1;
        @(posedge clka);
        #1;
        check_state(1'b0);
    endtask

    initial begin
        // Reset state
        @(posedge clka);
        #1;
        check_state(1'b0);
        @(negedge clka);
        rsta = 1'b1;
        @(posedge clka);
        #1;
        check_state(1'b0);

        // Local flit, then grant -> credit and empty
        cycle(1'b1, mk(4'd2, 4'd2, 40'h1), 1'b0);
        cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b0, 48'h0, 1'b0);

        // Route decode: east, west, north, south
        cycle(1'b1, mk(4'd3, 4'd2, 40'h11), 1'b0);
        cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b1, mk(4'd1, 4'd2, 40'h12), 1'b0);
        cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b1, mk(4'd2, 4'd3, 40'h13), 1'b0);
        cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b1, mk(4'd2, 4'd0, 40'h14), 1'b0);
        cycle(1'b0, 48'h0, 1'b1);

        // Grant while empty is ignored
        cycle(1'b0, 48'h0, 1'b1);

        // Fill, overflow drop of 0xE, drain A..D
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(4'd3, 4'd1, 40'hA + 40'(i)), 1'b0);
        cycle(1'b1, mk(4'd3, 4'd1, 40'hE), 1'b0);
        credit_tally = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 48'h0, 1'b1);
        check("drain_credits", 64'(credit_tally), 64'd4);
        cycle(1'b0, 48'h0, 1'b0);

        // Full with simultaneous push and grant: no overflow, order kept
        async_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(4'd1, 4'd3, 40'h20 + 40'(i)), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(4'd2, 4'd1, 40'h30 + 40'(i)), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b0, 48'h0, 1'b0);

        // Empty push+grant (grant ignored), then 20 cycles of streaming
        cycle(1'b1, mk(4'd0, 4'd0, 40'h100), 1'b1);
        credit_tally = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, mk(4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), 40'h200 + 40'(i)), 1'b1);
        end
        check("stream_credits", 64'(credit_tally), 64'd20);
        cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b0, 48'h0, 1'b0);

        // Asynchronous reset with three flits buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(4'd3, 4'd3, 40'h300 + 40'(i)), 1'b0);
        async_reset();
        cycle(1'b1, mk(4'd1, 4'd1, 40'h400), 1'b0);
        cycle(1'b0, 48'h0, 1'b1);
        cycle(1'b0, 48'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inport_buffered.md
Name: inport_buffered

Overview:
- Parametrised successor of the router input port.
- Accepts flits from an upstream link, buffers them in a FIFO of FIFO_DEPTH entries, and presents the head flit with a decoded XY route request to the switch allocator.
- Returns one credit per flit consumed, so the upstream sender never overruns the buffer.
- Sits between the link receiver and the crossbar/arbiter of one router port.

Parameters:
- X_LOCAL, 2, X coordinate of this router.
- Y_LOCAL, 2, Y coordinate of this router.
- COORD_W, 4, width of each destination coordinate field.
- DATA_W, 48, flit width; X dest = [DATA_W-1 -: COORD_W], Y dest = next COORD_W bits below it.
- FIFO_DEPTH, 4, buffer entries; power of 2, >= 2.

Ports:
- clka  in  1  clock.
- rsta  in  1  reset, asynchronous, active-low.
- valid_din  in  1  upstream flit valid, one flit per asserted cycle.
- channel_din  in  DATA_W  upstream flit.
- credit_dout  out  1  one-cycle pulse per flit popped.
- request_dout  out  1  head flit present (FIFO not empty).
- route_dout  out  5  one-hot route for head flit: [4]=local, [3]=north, [2]=south, [1]=east, [0]=west.
- x_hit_dout  out  1  head X dest == X_LOCAL.
- y_hit_dout  out  1  head Y dest == Y_LOCAL.
- packet_dout  out  DATA_W  head flit (first-word-fall-through).
- grant_din  in  1  allocator consumes head flit this cycle.
- overflow_dout  out  1  sticky: push attempted while full with no pop.
- count_dout  out  clog2(FIFO_DEPTH+1)  occupancy.

Behaviour:
- Reset (rsta=0, asynchronous):
  - Pointers, count, overflow and credit_dout clear.
  - request_dout=0, route_dout=0, x_hit/y_hit=0, packet_dout=0.
  - Storage contents need not clear.
  - Reset mid-operation discards all buffered flits.
  - Upstream re-initialises its credit counter to FIFO_DEPTH.
- Push:
  - Occurs when valid_din=1 and (not full, or pop in the same cycle).
  - Write at wr_ptr, wr_ptr wraps modulo FIFO_DEPTH.
- Pop:
  - Occurs when grant_din=1 and count>0.
  - rd_ptr wraps modulo FIFO_DEPTH.
  - grant_din while empty is ignored: no credit, no state change.
- Latency:
  - Flit pushed at edge N into an empty FIFO appears on packet_dout/request_dout after edge N; visible in cycle N+1.
  - No bypass of the empty FIFO in the same cycle.
- Head outputs:
  - packet_dout, route_dout, x_hit_dout and y_hit_dout are registered and reflect the FIFO head.
  - When the FIFO is empty they hold 0.
  - On pop with count>=2, the next entry is presented the following cycle: back-to-back grants sustain 1 flit/cycle.
- Route decode (XY, dimension-order):
  - If Xdest > X_LOCAL: east.
  - Else if Xdest < X_LOCAL: west.
  - Else if Ydest > Y_LOCAL: north.
  - Else if Ydest < Y_LOCAL: south.
  - Else: local.
  - Comparisons are unsigned, COORD_W bits.
  - Exactly one bit set whenever request_dout=1.
- Credit:
  - credit_dout=1 for exactly one cycle, in the cycle after each pop (registered).
  - Consecutive pops give consecutive credit pulses.
- Count:
  - Increments on push only, decrements on pop only, unchanged on simultaneous push+pop.
  - Range 0..FIFO_DEPTH.
- Full, push and pop in the same cycle: both accepted, count stays FIFO_DEPTH, no overflow.
- Empty, push and grant in the same cycle: grant ignored, push accepted, count becomes 1.
- Overflow:
  - valid_din=1 while full with no pop: flit dropped, FIFO unchanged.
  - overflow_dout set and held until reset.

Decomposition:
- Shared package holds:
  - Route index constants: ROUTE_LOCAL=4, ROUTE_NORTH=3, ROUTE_SOUTH=2, ROUTE_EAST=1, ROUTE_WEST=0.
  - Port count constant 5.
  - clog2 function.
- One sub-module, inport_fifo:
  - Parametrised on DATA_W and FIFO_DEPTH.
  - Contents: storage, pointers, count, full/empty, overflow.
- Top level adds:
  - Head registers.
  - Route decode.
  - Credit register.

Test Plan:
- Reset, then a single flit with X=2,Y=2 (0x22 in the top byte): request_dout=1 and route_dout=5'b10000 one cycle after the push; x_hit=y_hit=1; grant -> credit pulse next cycle, request_dout=0.
- Route decode with flits X=3,Y=2 / X=1,Y=2 / X=2,Y=3 / X=2,Y=0: route_dout = 00010 / 00001 / 01000 / 00100 in turn.
- Push 4 flits (0xA..0xD payloads) with no grant: count=4; a 5th push is dropped and overflow_dout=1; four grants then output A,B,C,D in order with 4 credit pulses; 0xE never appears.
- FIFO full, push plus grant in the same cycle: count stays 4, overflow stays 0, order preserved.
- Continuous push and grant for 20 cycles: 1 flit/cycle throughput, 20 credits, pointers wrap correctly with no loss or duplication.
- Assert rsta low mid-stream with count=3: all outputs 0 immediately (asynchronous); after release, request_dout=0 and new pushes start from an empty FIFO.
